// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle between a master (driver) and the register-bank slave.
interface axi_lite_slave_regs_if;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] AWADDR;
  logic        AWPROT;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] ARADDR;
  logic        ARPROT;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave with a bank of NUM_REGS byte-strobed 32-bit registers,
// independent AW/W capture, SLVERR for out-of-range accesses.
module axi_lite_slave_regs #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_LSB = 2
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  axi_lite_slave_regs_if.slave     s_axi,
  output logic [NUM_REGS*32-1:0]   regs_o
);

  localparam int unsigned IDX_W       = $clog2(NUM_REGS);
  localparam logic [31:0] RANGE_END   = 32'(NUM_REGS * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic              aw_held_q, aw_held_d;
  logic [31:0]       awaddr_q,  awaddr_d;
  logic              w_held_q,  w_held_d;
  logic [31:0]       wdata_q,   wdata_d;
  logic [3:0]        wstrb_q,   wstrb_d;
  logic              bvalid_q,  bvalid_d;
  logic [1:0]        bresp_q,   bresp_d;
  logic              rvalid_q,  rvalid_d;
  logic [1:0]        rresp_q,   rresp_d;
  logic [31:0]       rdata_q,   rdata_d;
  logic [31:0]       regs_q [NUM_REGS];
  logic [31:0]       regs_d [NUM_REGS];

  logic              awready_c, wready_c, arready_c;
  logic              aw_hs_c, w_hs_c, ar_hs_c, commit_c;
  logic [31:0]       wr_addr_c, wr_data_c;
  logic [3:0]        wr_strb_c;
  logic [IDX_W-1:0]  wr_idx_c, rd_idx_c;
  logic              wr_in_range_c, rd_in_range_c;
  logic              unused_prot;

  // Readies depend only on held state, never on incoming VALIDs.
  assign awready_c = ARESETN & ~aw_held_q & ~bvalid_q;
  assign wready_c  = ARESETN & ~w_held_q  & ~bvalid_q;
  assign arready_c = ARESETN & ~rvalid_q;

  assign aw_hs_c = s_axi.AWVALID & awready_c;
  assign w_hs_c  = s_axi.WVALID  & wready_c;
  assign ar_hs_c = s_axi.ARVALID & arready_c;

  // Held copies take priority; otherwise the channel handshaking this cycle supplies it.
  assign wr_addr_c = aw_held_q ? awaddr_q : s_axi.AWADDR;
  assign wr_data_c = w_held_q  ? wdata_q  : s_axi.WDATA;
  assign wr_strb_c = w_held_q  ? wstrb_q  : s_axi.WSTRB;
  assign commit_c  = (aw_held_q | aw_hs_c) & (w_held_q | w_hs_c);

  assign wr_idx_c      = wr_addr_c[ADDR_LSB +: IDX_W];
  assign rd_idx_c      = s_axi.ARADDR[ADDR_LSB +: IDX_W];
  assign wr_in_range_c = wr_addr_c < RANGE_END;
  assign rd_in_range_c = s_axi.ARADDR < RANGE_END;
  assign unused_prot   = s_axi.AWPROT ^ s_axi.ARPROT;

  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;

    if (aw_hs_c) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axi.AWADDR;
    end
    if (w_hs_c) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi.WDATA;
      wstrb_d  = s_axi.WSTRB;
    end

    if (bvalid_q && s_axi.BREADY) begin
      bvalid_d = 1'b0;
    end

    if (commit_c) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range_c ? RESP_OKAY : RESP_SLVERR;
      if (wr_in_range_c) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (wr_strb_c[b]) begin
            regs_d[wr_idx_c][8*b +: 8] = wr_data_c[8*b +: 8];
          end
        end
      end
    end
  end

  // Read samples regs_q, so a same-edge write is not yet visible.
  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rvalid_q && s_axi.RREADY) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs_c) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_in_range_c ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = rd_in_range_c ? regs_q[rd_idx_c] : 32'h0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      regs_q    <= '{default: '0};
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      regs_o[32*k +: 32] = regs_q[k];
    end
  end

  assign s_axi.AWREADY = awready_c;
  assign s_axi.WREADY  = wready_c;
  assign s_axi.ARREADY = arready_c;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RRESP   = rresp_q;
  assign s_axi.RDATA   = rdata_q;

endmodule
